// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and helpers for the memory-based radix-2 DIF FFT sequencer.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 4;
  localparam int unsigned FFT_N      = 32'd1 << FFT_N_LOG2;
  localparam int unsigned FFT_LAT    = 3;
  localparam int unsigned FFT_AW     = FFT_N_LOG2;
  localparam int unsigned FFT_TW     = FFT_N_LOG2 - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Stage counter width; never narrower than one bit.
  function automatic int unsigned stage_w(input int unsigned n_log2);
    return (n_log2 > 1) ? $clog2(n_log2) : 1;
  endfunction

endpackage

// File: rtl/fft_bf_ctrl_if.sv
// Control/BRAM/twiddle bundle between the FFT sequencer and its datapath.
interface fft_bf_ctrl_if import fft_pkg::*; #(
  parameter int unsigned N_LOG2 = FFT_N_LOG2
) ();

  localparam int unsigned SW = stage_w(N_LOG2);

  logic                start;
  logic                busy;
  logic                done;
  logic                ram_en;
  logic                ram_we;
  logic [N_LOG2-1:0]   ram_addr_a;
  logic [N_LOG2-1:0]   ram_addr_b;
  logic [N_LOG2-2:0]   tw_addr;
  logic [SW-1:0]       stage;

  modport master (
    input  start,
    output busy, done, ram_en, ram_we, ram_addr_a, ram_addr_b, tw_addr, stage
  );

  modport slave (
    output start,
    input  busy, done, ram_en, ram_we, ram_addr_a, ram_addr_b, tw_addr, stage
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Butterfly address map: (stage, j) -> paired BRAM addresses and twiddle ROM index.
module fft_addr_gen import fft_pkg::*; #(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned SW     = stage_w(N_LOG2)
) (
  input  logic [SW-1:0]     stage,
  input  logic [N_LOG2-2:0] j,
  output logic [N_LOG2-1:0] addr_a_c,
  output logic [N_LOG2-1:0] addr_b_c,
  output logic [N_LOG2-2:0] tw_addr_c
);

  localparam int unsigned AW = N_LOG2;
  localparam int unsigned TW = N_LOG2 - 1;

  int unsigned   pos;
  logic [AW-1:0] span;
  logic [AW-1:0] mask;
  logic [AW-1:0] jw;
  logic [AW-1:0] a;

  // Insert a zero at bit pos of j; span is the partner offset for this stage.
  always_comb begin
    pos       = N_LOG2 - 1 - 32'(stage);
    span      = AW'(1) << pos;
    mask      = span - AW'(1);
    jw        = AW'(j);
    a         = ((jw & ~mask) << 1) | (jw & mask);
    addr_a_c  = a;
    addr_b_c  = a | span;
    tw_addr_c = TW'((jw & mask) << stage);
  end

endmodule

// File: rtl/fft_bf_ctrl.sv
// In-place radix-2 DIF FFT sequencer: interleaved read/write-back on a true dual-port BRAM.
module fft_bf_ctrl import fft_pkg::*; #(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned LAT    = FFT_LAT
) (
  input logic            clk,
  input logic            rst_n,
  fft_bf_ctrl_if.master  bus
);

  localparam int unsigned N  = 32'd1 << N_LOG2;
  localparam int unsigned AW = N_LOG2;
  localparam int unsigned TW = N_LOG2 - 1;
  localparam int unsigned JW = N_LOG2 - 1;
  localparam int unsigned SW = stage_w(N_LOG2);
  localparam int unsigned CW = $clog2(N + LAT);

  localparam logic [CW-1:0] LAST_C = CW'(N + LAT - 2);
  localparam logic [JW-1:0] LAST_J = JW'(N / 2 - 1);
  localparam logic [SW-1:0] LAST_S = SW'(N_LOG2 - 1);

  state_e        state;
  logic [SW-1:0] stage_q;
  logic [JW-1:0] j_q;
  logic [CW-1:0] cyc_q;
  logic          busy_q, done_q, en_q, we_q;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic [TW-1:0] tw_q;

  logic          dl_v [LAT];
  logic [AW-1:0] dl_a [LAT];
  logic [AW-1:0] dl_b [LAT];

  logic          stage_end_c, rd_go_c, wr_go_c;
  logic [SW-1:0] gen_stage_c;
  logic [JW-1:0] gen_j_c;
  logic [AW-1:0] gen_a_c, gen_b_c;
  logic [TW-1:0] gen_tw_c;

  fft_addr_gen #(.N_LOG2(N_LOG2), .SW(SW)) u_addr_gen (
    .stage     (gen_stage_c),
    .j         (gen_j_c),
    .addr_a_c  (gen_a_c),
    .addr_b_c  (gen_b_c),
    .tw_addr_c (gen_tw_c)
  );

  // Decide what the next cycle carries: a read, a write-back, or nothing.
  always_comb begin
    stage_end_c = (state == RUN || state == DRAIN) && (cyc_q == LAST_C);
    rd_go_c     = 1'b0;
    wr_go_c     = 1'b0;
    gen_stage_c = stage_q;
    gen_j_c     = j_q;
    case (state)
      IDLE: begin
        rd_go_c     = bus.start;
        gen_stage_c = '0;
        gen_j_c     = '0;
      end
      RUN, DRAIN: begin
        if (stage_end_c) begin
          rd_go_c     = (stage_q != LAST_S);
          gen_stage_c = stage_q + SW'(1);
          gen_j_c     = '0;
        end else if (dl_v[LAT-1]) begin
          wr_go_c = 1'b1;
        end else begin
          rd_go_c = (state == RUN) && cyc_q[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stage_q  <= '0;
      j_q      <= '0;
      cyc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      for (int k = 0; k < LAT; k++) begin
        dl_v[k] <= 1'b0;
        dl_a[k] <= '0;
        dl_b[k] <= '0;
      end
    end else begin
      // Read addresses ride the delay line and come back as the write-back pair.
      dl_v[0] <= rd_go_c;
      dl_a[0] <= gen_a_c;
      dl_b[0] <= gen_b_c;
      for (int k = 1; k < LAT; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_a[k] <= dl_a[k-1];
        dl_b[k] <= dl_b[k-1];
      end

      done_q <= 1'b0;
      if (rd_go_c) begin
        en_q     <= 1'b1;
        we_q     <= 1'b0;
        addr_a_q <= gen_a_c;
        addr_b_q <= gen_b_c;
        tw_q     <= gen_tw_c;
      end else if (wr_go_c) begin
        en_q     <= 1'b1;
        we_q     <= 1'b1;
        addr_a_q <= dl_a[LAT-1];
        addr_b_q <= dl_b[LAT-1];
      end else begin
        en_q <= 1'b0;
        we_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            stage_q <= '0;
            j_q     <= JW'(1);
            cyc_q   <= '0;
          end
        end
        RUN, DRAIN: begin
          if (stage_end_c) begin
            cyc_q <= '0;
            if (stage_q == LAST_S) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state   <= RUN;
              stage_q <= stage_q + SW'(1);
              j_q     <= JW'(1);
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
            if (rd_go_c) begin
              j_q <= j_q + JW'(1);
              if (j_q == LAST_J) state <= DRAIN;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ram_en     = en_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_addr_a = addr_a_q;
  assign bus.ram_addr_b = addr_b_q;
  assign bus.tw_addr    = tw_q;
  assign bus.stage      = stage_q;

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Directed bench for fft_bf_ctrl at N_LOG2=4, LAT=3: cycle-exact trace of full transforms.
module tb_fft_bf_ctrl;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fft_bf_ctrl_if bus ();

  fft_bf_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int s1a  [8];
  int s1tw [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {busy, done, en, we, stage[1:0], a[3:0], b[3:0], tw[2:0]}
  function automatic logic [16:0] obs();
    return {bus.busy, bus.done, bus.ram_en, bus.ram_we, bus.stage,
            bus.ram_addr_a, bus.ram_addr_b, bus.tw_addr};
  endfunction

  // Build addr_a bit by bit, leaving a zero at position 3-s.
  function automatic int ins0(input int s, input int j);
    int r = 0;
    int k = 0;
    for (int bi = 0; bi < 4; bi++) begin
      if (bi != 3 - s) begin
        r = r | (((j >> k) & 1) << bi);
        k++;
      end
    end
    return r;
  endfunction

  task automatic check_cycle(input int rid, input int t);
    logic [16:0] e;
    logic [16:0] g;
    int s, c, j, a, span, tw;
    bit is_rd, is_wr;
    e = '0;
    g = obs();
    if (t < 72) begin
      s     = t / 18;
      c     = t % 18;
      span  = 16 >> (s + 1);
      is_rd = (c % 2 == 0) && (c <= 14);
      is_wr = (c % 2 == 1) && (c >= 3);
      j     = is_rd ? c / 2 : (c - 3) / 2;
      if (s == 1) begin
        a  = s1a[j];
        tw = s1tw[j];
      end else begin
        a  = ins0(s, j);
        tw = (j % span) << s;
      end
      e[16]    = 1'b1;
      e[12:11] = 2'(s);
      if (is_rd || is_wr) begin
        e[14]   = 1'b1;
        e[13]   = is_wr;
        e[10:7] = 4'(a);
        e[6:3]  = 4'(a + span);
        if (is_rd) e[2:0] = 3'(tw);
      end
    end else begin
      e[15]    = 1'b1;
      g[12:11] = 2'b00;
    end
    if (!e[14]) g[10:0] = '0;
    else if (e[13]) g[2:0] = '0;
    chk($sformatf("r%0d_t%0d", rid, t), 32'(g), 32'(e));
  endtask

  // Entered at the first cycle of a run; leaves one cycle after done.
  task automatic run_check(input int rid);
    for (int t = 0; t <= 72; t++) begin
      check_cycle(rid, t);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [16:0] v;
    int nen;
    s1a  = '{0, 1, 2, 3, 8, 9, 10, 11};
    s1tw = '{0, 2, 4, 6, 0, 2, 4, 6};
    rst_n     = 1'b0;
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    v = obs();
    chk("reset_outputs", 32'(v), 32'd0);
    rst_n = 1'b1;

    // Run 0: single-cycle start pulse.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_check(0);
    v = obs();
    chk("r0_idle_after_done", 32'(v[16:14]), 32'd0);

    // Run 1: start held high throughout; must be ignored until IDLE.
    bus.start = 1'b1;
    @(negedge clk);
    run_check(1);
    v = obs();
    chk("r1_idle_with_start_high", 32'(v[16:14]), 32'd0);
    @(negedge clk);
    check_cycle(2, 0);
    bus.start = 1'b0;

    // Run 2: aborted by asynchronous reset mid-stage.
    repeat (30) @(negedge clk);
    v = obs();
    chk("r2_pre_reset_en", 32'(v[14]), 32'd1);
    #2 rst_n = 1'b0;
    #1 v = obs();
    chk("async_reset_outputs", 32'(v), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nen = 0;
    repeat (12) begin
      @(negedge clk);
      nen += int'(bus.ram_en) + int'(bus.busy);
    end
    chk("quiet_after_reset", 32'(nen), 32'd0);

    // Run 3: clean full transform after abort.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_check(3);
    v = obs();
    chk("r3_idle_after_done", 32'(v[16:14]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
